// File: rtl/rs232tx_arbiter.sv
// rs232tx_arbiter
//   Shares one rs232tx transmitter among N byte-stream requesters. Grants are
//   round-robin at message granularity: the owner keeps the transmitter until
//   it sends a newline (8'h0A) or leaves its valid low for IDLE_TIMEOUT cycles,
//   so lines from different requesters never interleave.
//
//   Optional feature macro: RS232TX_ARB_TAG_EN
//     When defined, every grant is followed by two tag bytes ('0'+g, then ':')
//     before the owner's bytes are passed through.
//
// Ports
//   clock_i      clock, all logic on posedge
//   reset_i      asynchronous active-high reset
//   req_data_i   byte of requester i at [8*i+7:8*i]
//   req_valid_i  requester i has a byte
//   req_ready_o  byte of requester i accepted this cycle
//   tx_data_o    byte to rs232tx
//   tx_valid_o   valid to rs232tx
//   tx_ready_i   ready from rs232tx
//   grant_id_o   current owner index (meaningful while busy_o=1)
//   busy_o       a requester currently holds the transmitter

module rs232tx_arbiter #(
    parameter int N            = 4,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int TW           = 11
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [N*8-1:0]   req_data_i,
    input  logic [N-1:0]     req_valid_i,
    output logic [N-1:0]     req_ready_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_valid_o,
    input  logic             tx_ready_i,
    output logic [2:0]       grant_id_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TAG0 = 2'd1,
        S_TAG1 = 2'd2,
        S_PASS = 2'd3
    } state_t;

    state_t          state_q;
    logic [2:0]      g_q;
    logic [2:0]      rr_q;
    logic            busy_q;
    logic [TW-1:0]   cnt_q;

    logic            found;
    logic [2:0]      sel;
    logic            owner_valid;
    logic [7:0]      owner_data;
    logic            xfer;
    logic            timeout;
    logic [2:0]      rr_next;

    // First set req_valid at or above rr_q, wrapping N-1 -> 0. The double loop
    // compares against constant indices so no variable bit-select is needed.
    always_comb begin
        found = 1'b0;
        sel   = 3'd0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req_valid_i[i] &&
                    (({1'b0, rr_q} + 4'(k) == 4'(i)) ||
                     ({1'b0, rr_q} + 4'(k) == 4'(i + N)))) begin
                    found = 1'b1;
                    sel   = 3'(i);
                end
            end
        end
    end

    always_comb begin
        owner_valid = 1'b0;
        owner_data  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (g_q == 3'(i)) begin
                owner_valid = req_valid_i[i];
                owner_data  = req_data_i[8*i +: 8];
            end
        end
    end

    // Pass-through is combinational so the owner sees no added byte latency.
    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        req_ready_o = '0;
        case (state_q)
            S_PASS: begin
                tx_valid_o = owner_valid;
                tx_data_o  = owner_data;
                for (int i = 0; i < N; i++) begin
                    req_ready_o[i] = (g_q == 3'(i)) && tx_ready_i;
                end
            end
`ifdef RS232TX_ARB_TAG_EN
            S_TAG0: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h30 + {5'd0, g_q};
            end
            S_TAG1: begin
                tx_valid_o = 1'b1;
                tx_data_o  = 8'h3A;
            end
`endif
            default: ;
        endcase
    end

    assign xfer    = tx_valid_o && tx_ready_i;
    assign timeout = !owner_valid && (cnt_q == TW'(IDLE_TIMEOUT - 1));
    assign rr_next = (g_q == 3'(N - 1)) ? 3'd0 : g_q + 3'd1;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            g_q     <= 3'd0;
            rr_q    <= 3'd0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        g_q    <= sel;
                        busy_q <= 1'b1;
                        cnt_q  <= '0;
`ifdef RS232TX_ARB_TAG_EN
                        state_q <= S_TAG0;
`else
                        state_q <= S_PASS;
`endif
                    end
                end
`ifdef RS232TX_ARB_TAG_EN
                S_TAG0: if (xfer) state_q <= S_TAG1;
                S_TAG1: if (xfer) state_q <= S_PASS;
`endif
                S_PASS: begin
                    // A transfer implies owner_valid, so newline and timeout
                    // can never both fire; either gives a single release.
                    if ((xfer && tx_data_o == 8'h0A) || timeout) begin
                        rr_q    <= rr_next;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (xfer) begin
                        cnt_q <= '0;
                    end else if (!owner_valid && cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant_id_o = g_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_rs232tx_arbiter.sv
// Directed testbench for rs232tx_arbiter (N=4, IDLE_TIMEOUT=16).
// Inputs change at the falling edge; outputs are sampled 1 ns later.

module tb_rs232tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic          clk;
    logic          rst;
    logic [N*8-1:0] req_data;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [2:0]    grant_id;
    logic          busy;

    int checks = 0;
    int errors = 0;

    rs232tx_arbiter #(.N(N), .IDLE_TIMEOUT(TO), .TW(5)) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .req_data_i (req_data),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .grant_id_o (grant_id),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    // Consumes the two tag bytes when tagging is built in; no-op otherwise.
    task automatic skip_tags();
`ifdef RS232TX_ARB_TAG_EN
        next_cyc(); tx_ready = 1'b1;
        next_cyc(); tx_ready = 1'b1;
`endif
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 100; i++) begin
            next_cyc(); #1;
            checks++;
            if (tx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: tx_valid=%b busy=%b req_ready=%b expected 0 0 0000",
                         i, tx_valid, busy, req_ready);
            end
        end
    endtask

    task automatic test_line();
        logic [7:0] msg [3];
        msg[0] = 8'h68; msg[1] = 8'h69; msg[2] = 8'h0A;
        next_cyc();
        req_valid = 4'b0100; req_data[23:16] = 8'h68; tx_ready = 1'b0;
        #1; checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL line_pre_grant: busy=%b expected 0", busy);
        end
        next_cyc(); #1; checks++;
        if (busy !== 1'b1 || grant_id !== 3'd2) begin
            errors++; $display("FAIL line_grant: busy=%b grant=%0d expected 1 2", busy, grant_id);
        end
        skip_tags();
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            req_data[23:16] = msg[i]; tx_ready = 1'b1;
            #1; checks++;
            if (tx_valid !== 1'b1 || tx_data !== msg[i] || req_ready !== 4'b0100) begin
                errors++;
                $display("FAIL line_byte%0d: valid=%b data=%h ready=%b expected 1 %h 0100",
                         i, tx_valid, tx_data, req_ready, msg[i]);
            end
        end
        next_cyc();
        tx_ready = 1'b0; req_valid = '0;
        #1; checks++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            errors++; $display("FAIL line_release: busy=%b tx_valid=%b expected 0 0", busy, tx_valid);
        end
        // rr pointer now 3: with 0 and 3 both waiting, 3 must win.
        next_cyc();
        req_valid = 4'b1001; req_data[31:24] = 8'h0A; req_data[7:0] = 8'h0A;
        next_cyc(); #1; checks++;
        if (busy !== 1'b1 || grant_id !== 3'd3) begin
            errors++; $display("FAIL line_rr_ptr: busy=%b grant=%0d expected 1 3", busy, grant_id);
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        rst = 1'b1; tx_ready = 1'b0;
        req_valid = 4'b1001; req_data = '0;
        req_data[7:0] = 8'h41; req_data[31:24] = 8'h0A;
        next_cyc(); next_cyc();
        rst = 1'b0;
        next_cyc(); #1; checks++;
        if (busy !== 1'b1 || grant_id !== 3'd0) begin
            errors++; $display("FAIL rr_first: busy=%b grant=%0d expected 1 0", busy, grant_id);
        end
        skip_tags();
        next_cyc(); tx_ready = 1'b1; #1; checks++;
        if (tx_data !== 8'h41 || req_ready !== 4'b0001) begin
            errors++; $display("FAIL rr_byte0: data=%h ready=%b expected 41 0001", tx_data, req_ready);
        end
        next_cyc(); req_data[7:0] = 8'h0A; #1; checks++;
        if (tx_data !== 8'h0A) begin
            errors++; $display("FAIL rr_nl0: data=%h expected 0a", tx_data);
        end
        next_cyc(); tx_ready = 1'b0; #1; checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rr_release0: busy=%b expected 0", busy);
        end
        next_cyc(); #1; checks++;
        if (busy !== 1'b1 || grant_id !== 3'd3) begin
            errors++; $display("FAIL rr_second: busy=%b grant=%0d expected 1 3", busy, grant_id);
        end
        skip_tags();
        next_cyc(); tx_ready = 1'b1; #1; checks++;
        if (tx_data !== 8'h0A || req_ready !== 4'b1000) begin
            errors++; $display("FAIL rr_byte3: data=%h ready=%b expected 0a 1000", tx_data, req_ready);
        end
        next_cyc(); tx_ready = 1'b0; #1; checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rr_release3: busy=%b expected 0", busy);
        end
        next_cyc(); #1; checks++;
        if (busy !== 1'b1 || grant_id !== 3'd0) begin
            errors++; $display("FAIL rr_wrap: busy=%b grant=%0d expected 1 0", busy, grant_id);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        next_cyc();
        req_valid = 4'b0110; req_data[15:8] = 8'h41; req_data[23:16] = 8'h42;
        next_cyc(); #1; checks++;
        if (busy !== 1'b1 || grant_id !== 3'd1) begin
            errors++; $display("FAIL to_grant: busy=%b grant=%0d expected 1 1", busy, grant_id);
        end
        skip_tags();
        next_cyc(); tx_ready = 1'b1; #1; checks++;
        if (tx_data !== 8'h41 || req_ready !== 4'b0010) begin
            errors++; $display("FAIL to_byte: data=%h ready=%b expected 41 0010", tx_data, req_ready);
        end
        for (int n = 0; n <= TO; n++) begin
            next_cyc();
            if (n == 0) begin
                req_valid[1] = 1'b0; tx_ready = 1'b0;
            end
            #1; checks++;
            if (n < TO) begin
                if (busy !== 1'b1 || tx_valid !== 1'b0 || grant_id !== 3'd1) begin
                    errors++;
                    $display("FAIL to_hold n=%0d: busy=%b tx_valid=%b grant=%0d expected 1 0 1",
                             n, busy, tx_valid, grant_id);
                end
            end else if (busy !== 1'b0) begin
                errors++; $display("FAIL to_release n=%0d: busy=%b expected 0", n, busy);
            end
        end
        next_cyc(); #1; checks++;
        if (busy !== 1'b1 || grant_id !== 3'd2) begin
            errors++; $display("FAIL to_next: busy=%b grant=%0d expected 1 2", busy, grant_id);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        next_cyc();
        req_valid = 4'b0001; req_data[7:0] = 8'h55; tx_ready = 1'b0;
        next_cyc(); #1; checks++;
        if (tx_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL ar_pre: tx_valid=%b busy=%b expected 1 1", tx_valid, busy);
        end
        next_cyc(); #2;
        tx_ready = 1'b1; rst = 1'b1;
        #1; checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL ar_async: tx_valid=%b busy=%b ready=%b expected 0 0 0000",
                     tx_valid, busy, req_ready);
        end
        next_cyc(); req_valid = '0; tx_ready = 1'b0;
        next_cyc(); rst = 1'b0;
        next_cyc(); #1; checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ar_idle: tx_valid=%b busy=%b expected 0 0", tx_valid, busy);
        end
    endtask

`ifdef RS232TX_ARB_TAG_EN
    task automatic test_tags();
        logic [7:0] exp_b [3];
        logic [3:0] exp_r [3];
        exp_b[0] = 8'h32; exp_b[1] = 8'h3A; exp_b[2] = 8'h0A;
        exp_r[0] = 4'b0000; exp_r[1] = 4'b0000; exp_r[2] = 4'b0100;
        do_reset();
        next_cyc();
        req_valid = 4'b0100; req_data[23:16] = 8'h0A; tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_cyc(); #1; checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp_b[i] || req_ready !== exp_r[i]) begin
                errors++;
                $display("FAIL tag_byte%0d: valid=%b data=%h ready=%b expected 1 %h %b",
                         i, tx_valid, tx_data, req_ready, exp_b[i], exp_r[i]);
            end
        end
        next_cyc(); req_valid = '0; tx_ready = 1'b0; #1; checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL tag_release: busy=%b expected 0", busy);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        test_reset();
        test_line();
        test_round_robin();
        test_timeout();
        test_async_reset();
`ifdef RS232TX_ARB_TAG_EN
        test_tags();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
